// File: rtl/tcp_arb_pkg.sv
// Shared types and field positions for the TCP TX arbiter.
// Metadata is {length, session_id}; status error code sits in the top bits.
package tcp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        META = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int META_LEN_MSB   = 47;
    localparam int META_LEN_LSB   = 16;
    localparam int META_SID_MSB   = 15;
    localparam int META_SID_LSB   = 0;
    localparam int STATUS_ERR_MSB = 63;
    localparam int STATUS_ERR_LSB = 62;
    localparam int BYTES_PER_BEAT = 64;
    localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
    localparam int LEN_W          = META_LEN_MSB - META_LEN_LSB + 1;
    localparam int BEATS_W        = LEN_W + 1 - BEAT_SHIFT;

    // ceil(len / bytes-per-beat) with one extra bit so len near 2^32 cannot wrap
    function automatic logic [BEATS_W-1:0] len_to_beats(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + (LEN_W + 1)'(BYTES_PER_BEAT - 1);
        return BEATS_W'(sum >> BEAT_SHIFT);
    endfunction

endpackage

// File: rtl/tcp_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// scanning upward with wrap.
module rr_pick
    import tcp_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int GW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    ptr,
    output logic [GW-1:0]    gnt_idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;

    assign rot = N_REQ'({req, req} >> ptr);

    // scan downward so the lowest rotated offset is the one that sticks
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                any     = 1'b1;
                gnt_idx = GW'((int'(ptr) + j) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Transaction-level round-robin arbiter sharing one TCP TX port among
// N_REQ send engines; meta beat then all data beats up to last.
module tcp_tx_arbiter
    import tcp_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 512,
    parameter int META_W   = 48,
    parameter int STATUS_W = 64,
    localparam int GW      = $clog2(N_REQ),
    localparam int KEEP_W  = DATA_W / 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic [N_REQ-1:0]        s_meta_valid,
    output logic [N_REQ-1:0]        s_meta_ready,
    input  logic [N_REQ*META_W-1:0] s_meta_data,
    input  logic [N_REQ-1:0]        s_data_valid,
    output logic [N_REQ-1:0]        s_data_ready,
    input  logic [N_REQ*DATA_W-1:0] s_data_data,
    input  logic [N_REQ*KEEP_W-1:0] s_data_keep,
    input  logic [N_REQ-1:0]        s_data_last,
    output logic                    m_meta_valid,
    input  logic                    m_meta_ready,
    output logic [META_W-1:0]       m_meta_data,
    output logic                    m_data_valid,
    input  logic                    m_data_ready,
    output logic [DATA_W-1:0]       m_data_data,
    output logic [KEEP_W-1:0]       m_data_keep,
    output logic                    m_data_last,
    input  logic                    s_status_valid,
    output logic                    s_status_ready,
    input  logic [STATUS_W-1:0]     s_status_data,
    output logic [GW-1:0]           cur_grant,
    output logic                    busy,
    output logic [31:0]             grant_cnt,
    output logic [31:0]             word_cnt,
    output logic [31:0]             len_err_cnt,
    output logic [31:0]             status_err_cnt
);

    state_t             state;
    logic [GW-1:0]      rr_ptr;
    logic [GW-1:0]      next_ptr;
    logic [GW-1:0]      pick_idx;
    logic               pick_any;
    logic [LEN_W-1:0]   g_len;
    logic [BEATS_W-1:0] exp_beats;
    logic [BEATS_W-1:0] beat_cnt;
    logic [BEATS_W-1:0] beat_nxt;
    logic               meta_hs;
    logic               data_hs;
    logic               status_err;
    logic               unused_status;

    rr_pick #(
        .N_REQ   (N_REQ)
    ) u_rr_pick (
        .req     (s_meta_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign g_len = s_meta_data[cur_grant*META_W + META_LEN_LSB +: LEN_W];

    assign m_meta_valid = (state == META) && s_meta_valid[cur_grant];
    assign m_meta_data  = s_meta_data[cur_grant*META_W +: META_W];
    assign m_data_valid = (state == DATA) && s_data_valid[cur_grant];
    assign m_data_data  = s_data_data[cur_grant*DATA_W +: DATA_W];
    assign m_data_keep  = s_data_keep[cur_grant*KEEP_W +: KEEP_W];
    assign m_data_last  = s_data_last[cur_grant];

    always_comb begin
        s_meta_ready = '0;
        s_data_ready = '0;
        if (state == META) s_meta_ready[cur_grant] = m_meta_ready;
        if (state == DATA) s_data_ready[cur_grant] = m_data_ready;
    end

    assign meta_hs  = m_meta_valid && m_meta_ready;
    assign data_hs  = m_data_valid && m_data_ready;
    assign beat_nxt = beat_cnt + BEATS_W'(1);
    assign next_ptr = (cur_grant == GW'(N_REQ - 1)) ? '0 : cur_grant + GW'(1);

    assign s_status_ready = 1'b1;
    assign status_err     = |s_status_data[STATUS_ERR_MSB:STATUS_ERR_LSB];
    assign unused_status  = ^s_status_data[STATUS_ERR_LSB-1:0];
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            cur_grant      <= '0;
            exp_beats      <= '0;
            beat_cnt       <= '0;
            grant_cnt      <= '0;
            word_cnt       <= '0;
            len_err_cnt    <= '0;
            status_err_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en && pick_any) begin
                        cur_grant <= pick_idx;
                        state     <= META;
                    end
                end
                META: begin
                    if (meta_hs) begin
                        exp_beats <= len_to_beats(g_len);
                        beat_cnt  <= '0;
                        // zero-length sends carry no data beats at all
                        if (g_len == '0) begin
                            state     <= IDLE;
                            rr_ptr    <= next_ptr;
                            grant_cnt <= grant_cnt + 32'd1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (data_hs) begin
                        beat_cnt <= beat_nxt;
                        word_cnt <= word_cnt + 32'd1;
                        if (m_data_last) begin
                            state     <= IDLE;
                            rr_ptr    <= next_ptr;
                            grant_cnt <= grant_cnt + 32'd1;
                            if (beat_nxt != exp_beats)
                                len_err_cnt <= len_err_cnt + 32'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (s_status_valid && status_err)
                status_err_cnt <= status_err_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed bench for tcp_tx_arbiter: table of transaction scenarios
// plus hand sequences for en gating, status errors and mid-DATA reset.
module tb_tcp_tx_arbiter;
    import tcp_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 512;
    localparam int MW = 48;
    localparam int SW = 64;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic           keep;
        logic           rnd;
        logic [3:0]     mask;
        logic [3:0][31:0] len;
        logic [3:0][7:0]  beats;
        logic [2:0]     n;
        logic [3:0][1:0]  ord;
        logic [31:0]    g;
        logic [31:0]    w;
        logic [31:0]    e;
    } vec_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic            en;
    logic [N-1:0]    s_meta_valid, s_meta_ready;
    logic [N*MW-1:0] s_meta_data;
    logic [N-1:0]    s_data_valid, s_data_ready;
    logic [N*DW-1:0] s_data_data;
    logic [N*KW-1:0] s_data_keep;
    logic [N-1:0]    s_data_last;
    logic            m_meta_valid, m_meta_ready;
    logic [MW-1:0]   m_meta_data;
    logic            m_data_valid, m_data_ready;
    logic [DW-1:0]   m_data_data;
    logic [KW-1:0]   m_data_keep;
    logic            m_data_last;
    logic            s_status_valid, s_status_ready;
    logic [SW-1:0]   s_status_data;
    logic [1:0]      cur_grant;
    logic            busy;
    logic [31:0]     grant_cnt, word_cnt, len_err_cnt, status_err_cnt;

    int   checks, errors;
    int   n_ord, bad_rdy, bad_dat, n_beats;
    int   ord_q[8];
    int   ord_cyc[8];
    logic snap_busy;
    logic [1:0] snap_grant;
    vec_t vecs[8];

    tcp_tx_arbiter #(
        .N_REQ(N), .DATA_W(DW), .META_W(MW), .STATUS_W(SW)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready),
        .s_meta_data(s_meta_data),
        .s_data_valid(s_data_valid), .s_data_ready(s_data_ready),
        .s_data_data(s_data_data), .s_data_keep(s_data_keep),
        .s_data_last(s_data_last),
        .m_meta_valid(m_meta_valid), .m_meta_ready(m_meta_ready),
        .m_meta_data(m_meta_data),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
        .m_data_data(m_data_data), .m_data_keep(m_data_keep),
        .m_data_last(m_data_last),
        .s_status_valid(s_status_valid), .s_status_ready(s_status_ready),
        .s_status_data(s_status_data),
        .cur_grant(cur_grant), .busy(busy),
        .grant_cnt(grant_cnt), .word_cnt(word_cnt),
        .len_err_cnt(len_err_cnt), .status_err_cnt(status_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i, input int k);
        return {16{32'(i * 1000 + k + 1)}};
    endfunction

    function automatic vec_t mkv(
        input logic kp, input logic rn, input logic [3:0] m,
        input int l0, input int l1, input int l2, input int l3,
        input int b0, input int b1, input int b2, input int b3,
        input int n, input int o0, input int o1, input int o2, input int o3,
        input int g, input int w, input int e);
        vec_t v;
        v.keep = kp; v.rnd = rn; v.mask = m;
        v.len[0] = l0; v.len[1] = l1; v.len[2] = l2; v.len[3] = l3;
        v.beats[0] = 8'(b0); v.beats[1] = 8'(b1);
        v.beats[2] = 8'(b2); v.beats[3] = 8'(b3);
        v.n = 3'(n);
        v.ord[0] = 2'(o0); v.ord[1] = 2'(o1);
        v.ord[2] = 2'(o2); v.ord[3] = 2'(o3);
        v.g = g; v.w = w; v.e = e;
        return v;
    endfunction

    task automatic clr_inputs;
        en = 1'b0;
        s_meta_valid = '0; s_meta_data = '0;
        s_data_valid = '0; s_data_data = '0;
        s_data_keep = '0; s_data_last = '0;
        m_meta_ready = 1'b1; m_data_ready = 1'b1;
        s_status_valid = 1'b0; s_status_data = '0;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        clr_inputs();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Cycle-by-cycle requester model; starts and ends just after a negedge.
    task automatic run(input vec_t v, input int en_lo, input int en_hi,
                       input int snap_c, input int rst_at);
        logic [N-1:0] pend, mh, dh, act_oh;
        int left[N];
        int sent[N];
        int act, mi, di;
        bit fin;
        n_ord = 0; bad_rdy = 0; bad_dat = 0; n_beats = 0;
        fin = 0; act = -1; pend = v.mask;
        for (int i = 0; i < N; i++) begin
            left[i] = 0; sent[i] = 0;
        end
        for (int c = 0; c < 400 && !fin; c++) begin
            en = !(c >= en_lo && c < en_hi);
            m_data_ready = v.rnd ? 1'($urandom_range(1)) : 1'b1;
            for (int i = 0; i < N; i++) begin
                s_meta_valid[i] = pend[i];
                s_meta_data[i*MW +: MW] = {v.len[i], 16'(256 + i)};
                s_data_valid[i] = !pend[i] && left[i] > 0;
                s_data_data[i*DW +: DW] = pat(i, sent[i]);
                s_data_keep[i*KW +: KW] = '1;
                s_data_last[i] = (left[i] == 1);
            end
            if (c == rst_at) begin
                chk("pre_rst_grant_cnt", grant_cnt, 1);
                rstn = 1'b0;
                #1;
                chk("rst_m_meta_valid", 32'(m_meta_valid), 0);
                chk("rst_m_data_valid", 32'(m_data_valid), 0);
                chk("rst_s_meta_ready", 32'(s_meta_ready), 0);
                chk("rst_s_data_ready", 32'(s_data_ready), 0);
                chk("rst_status_ready", 32'(s_status_ready), 1);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_cur_grant", 32'(cur_grant), 0);
                chk("rst_grant_cnt", grant_cnt, 0);
                chk("rst_word_cnt", word_cnt, 0);
                return;
            end
            #4;
            if (c == snap_c) begin
                snap_busy = busy;
                snap_grant = cur_grant;
            end
            act_oh = (act >= 0) ? N'(1) << act : '0;
            if ((s_data_ready & ~act_oh) != 0 || (s_meta_ready & ~pend) != 0 ||
                $countones(s_meta_ready | s_data_ready) > 1 ||
                (act >= 0 && s_meta_ready != 0) ||
                (!busy && (m_meta_valid || m_data_valid)))
                bad_rdy++;
            mh = s_meta_valid & s_meta_ready;
            dh = s_data_valid & s_data_ready;
            if ((m_meta_valid && m_meta_ready) != (mh != 0)) bad_dat++;
            if ((m_data_valid && m_data_ready) != (dh != 0)) bad_dat++;
            mi = -1; di = -1;
            for (int i = 0; i < N; i++) begin
                if (mh[i]) mi = i;
                if (dh[i]) di = i;
            end
            if (mi >= 0) begin
                if (m_meta_data != {v.len[mi], 16'(256 + mi)}) bad_dat++;
                if (n_ord < 8) begin
                    ord_q[n_ord] = mi;
                    ord_cyc[n_ord] = c;
                end
                n_ord++;
            end
            if (di >= 0) begin
                if (m_data_data != pat(di, sent[di]) || m_data_keep != '1 ||
                    m_data_last != (left[di] == 1) || di != act)
                    bad_dat++;
                n_beats++;
            end
            @(posedge clk);
            if (mi >= 0) begin
                pend[mi] = 1'b0;
                left[mi] = int'(v.beats[mi]);
                if (left[mi] > 0) act = mi;
            end
            if (di >= 0) begin
                sent[di]++;
                left[di]--;
                if (left[di] == 0) act = -1;
            end
            fin = (pend == 0);
            for (int i = 0; i < N; i++)
                if (left[i] != 0) fin = 0;
            @(negedge clk);
        end
        chk("run_completed", 32'(fin), 1);
    endtask

    initial begin
        int sum;
        logic [1:0] st_code[6];
        logic       st_vld[6];
        checks = 0; errors = 0;
        snap_busy = 1'b1; snap_grant = '0;

        vecs[0] = mkv(0, 0, 4'b0001, 256, 0, 0, 0, 4, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 0);
        vecs[1] = mkv(0, 0, 4'b1111, 128, 128, 128, 128, 2, 2, 2, 2, 4, 0, 1, 2, 3, 4, 8, 0);
        vecs[2] = mkv(0, 0, 4'b0001, 100, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2, 0);
        vecs[3] = mkv(0, 0, 4'b0001, 100, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 1);
        vecs[4] = mkv(0, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        vecs[5] = mkv(0, 1, 4'b0110, 0, 640, 64, 0, 0, 10, 1, 0, 2, 1, 2, 0, 0, 2, 11, 0);
        vecs[6] = mkv(1, 0, 4'b1001, 64, 0, 0, 64, 1, 0, 0, 1, 2, 3, 0, 0, 0, 4, 13, 0);
        vecs[7] = mkv(0, 0, 4'b1010, 0, 65, 0, 64, 0, 2, 0, 2, 2, 1, 3, 0, 0, 2, 4, 1);

        do_reset();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_cur_grant", 32'(cur_grant), 0);
        chk("reset_grant_cnt", grant_cnt, 0);
        chk("reset_word_cnt", word_cnt, 0);
        chk("reset_len_err_cnt", len_err_cnt, 0);
        chk("reset_status_err_cnt", status_err_cnt, 0);
        chk("reset_m_valids", 32'({m_meta_valid, m_data_valid}), 0);
        chk("reset_s_readies", 32'({s_meta_ready, s_data_ready}), 0);
        chk("reset_status_ready", 32'(s_status_ready), 1);

        for (int r = 0; r < 8; r++) begin
            if (!vecs[r].keep) do_reset();
            run(vecs[r], -1, -1, -1, -1);
            sum = 0;
            for (int i = 0; i < N; i++) sum += int'(vecs[r].beats[i]);
            chk($sformatf("v%0d_grants_seen", r), n_ord, 32'(vecs[r].n));
            for (int k = 0; k < int'(vecs[r].n); k++)
                chk($sformatf("v%0d_order%0d", r, k), ord_q[k], 32'(vecs[r].ord[k]));
            chk($sformatf("v%0d_grant_cnt", r), grant_cnt, vecs[r].g);
            chk($sformatf("v%0d_word_cnt", r), word_cnt, vecs[r].w);
            chk($sformatf("v%0d_len_err_cnt", r), len_err_cnt, vecs[r].e);
            chk($sformatf("v%0d_beats_seen", r), n_beats, sum);
            chk($sformatf("v%0d_ready_violations", r), bad_rdy, 0);
            chk($sformatf("v%0d_data_mismatches", r), bad_dat, 0);
        end

        // en low while requester 1 is in DATA; requester 2 must wait for en
        do_reset();
        run(mkv(0, 0, 4'b0110, 0, 256, 64, 0, 0, 4, 1, 0, 2, 1, 2, 0, 0, 2, 5, 0),
            2, 12, 10, -1);
        chk("en_grants_seen", n_ord, 2);
        chk("en_first", ord_q[0], 1);
        chk("en_second", ord_q[1], 2);
        chk("en_second_meta_cycle", ord_cyc[1], 13);
        chk("en_idle_busy", 32'(snap_busy), 0);
        chk("en_idle_cur_grant", 32'(snap_grant), 1);
        chk("en_grant_cnt", grant_cnt, 2);
        chk("en_word_cnt", word_cnt, 5);
        chk("en_violations", bad_rdy + bad_dat, 0);

        // status beats: codes 0,1,2 valid, 3 with valid low, then two OK beats
        do_reset();
        st_vld  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        st_code = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        for (int k = 0; k < 6; k++) begin
            s_status_valid = st_vld[k];
            s_status_data = {st_code[k], 62'h1555_5555_5555_5555};
            #4;
            chk($sformatf("status_ready%0d", k), 32'(s_status_ready), 1);
            @(negedge clk);
        end
        s_status_valid = 1'b0;
        chk("status_err_cnt", status_err_cnt, 2);
        chk("status_grant_cnt", grant_cnt, 0);

        // asynchronous reset in the middle of requester 1's data
        do_reset();
        run(mkv(0, 0, 4'b0011, 64, 640, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
            -1, -1, -1, 8);
        do_reset();
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_len_err_cnt", len_err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
